mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
- Debug/run controller between the UART FIFOs and the MIPS_DLX core.
- Pops command bytes from the UART receive FIFO and gates the core clock-enable for continuous run, single-step or no execution.
- After each command, snapshots the core's debug_signal bus and streams it out byte-serially through the UART transmit FIFO.
- Sole owner of the core `enable`; the UART block only moves bytes.

Parameters:
- DEBUG_W, 322: width of debug_signal; frame length NBYTES = ceil(DEBUG_W/8), which is 41 at the default.
- CMD_RUN, 8'h63 ('c'): run until halt, then dump.
- CMD_STEP, 8'h73 ('s'): execute exactly one enabled cycle, then dump.
- CMD_DUMP, 8'h64 ('d'): dump only, no execution.

Ports:
- clock  in  1  system clock (core clock domain).
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  head of UART rx FIFO, valid while rx_empty=0.
- rx_empty  in  1  rx FIFO empty.
- rd  out  1  one-cycle pop of rx FIFO.
- tx_full  in  1  tx FIFO full.
- wr  out  1  one-cycle push into tx FIFO.
- w_data  out  8  byte pushed with wr.
- halt  in  1  core has reached HALT (level).
- debug_signal  in  DEBUG_W  core state bus.
- enable  out  1  core clock-enable (registered).

Behaviour:
- Reset (synchronous, active-high) forces:
  - rd=0, wr=0, w_data=0, enable=0;
  - state=IDLE, byte index=0, snapshot=0.
- Reset mid-run or mid-send aborts immediately; no further wr or enable after the reset cycle.
- All outputs are registered.
- States: IDLE, DECODE, RUN, STEP, SETTLE, LATCH, SEND.
- IDLE:
  - If rx_empty=0: capture rx_data, pulse rd for exactly 1 cycle, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - CMD_RUN: go to RUN, or to SETTLE if halt=1 (no enabled cycles).
  - CMD_STEP: go to STEP.
  - CMD_DUMP: go to SETTLE.
  - Any other byte: discard and return to IDLE (no tx traffic).
- RUN:
  - enable=1 every cycle.
  - When halt is sampled 1, deassert enable the next cycle and go to SETTLE.
  - Further rx bytes are left in the FIFO (not popped) until IDLE.
- STEP:
  - enable=1 for exactly one clock, regardless of halt, then go to SETTLE.
  - enable rises 2 cycles after the rd pulse.
- SETTLE: one idle cycle so registered core outputs update. Go to LATCH.
- LATCH: snapshot <= debug_signal; index <= 0. Go to SEND.
- SEND:
  - When tx_full=0: wr=1, w_data=snapshot[8*index +: 8], index++.
  - When tx_full=1: wr=0 and index holds. A full FIFO is never written.
  - Bytes go out LSB-first. Bits of the last byte beyond DEBUG_W are sent as 0.
  - After byte NBYTES-1 is written, return to IDLE.
- The earliest first wr is 3 cycles after enable falls (SETTLE, LATCH, SEND).
- enable is never high outside RUN and STEP.
- rd and wr are never high in the same cycle.

Optional Feature:
- Macro: MIPS_DBG_CYCLE_COUNT_EN.
- Defined:
  - A 32-bit counter increments on every cycle with enable=1, cleared by reset, wrapping at 2^32-1 -> 0.
  - It is latched in LATCH alongside the snapshot.
  - Its 4 bytes are sent LSB-first after the debug frame, giving NBYTES+4 bytes per dump.
- Undefined: no counter logic; the frame is exactly NBYTES bytes.

Decomposition:
- Shared include (definiciones.vh):
  - DEBUG width macro;
  - CMD_RUN/CMD_STEP/CMD_DUMP codes;
  - state encoding localparams.
- One sub-module, dbg_frame_tx:
  - snapshot register, index counter, tx_full/wr handshake and optional counter bytes;
  - inputs: start, data; output: done.
- mips_debug_ctrl keeps the command FSM and enable generation.

Test Plan:
1. Push 8'h64, tx_full=0, debug_signal=322'h1_2345...: one rd pulse, enable stays 0, exactly 41 wr. Byte 0 = debug_signal[7:0]; byte 40 = {6'b0, debug_signal[321:320]}.
2. Push 8'h73: enable high exactly 1 cycle, 2 cycles after rd; first wr 3 cycles after enable falls; 41 bytes.
3. Push 8'h63, halt asserted 10 cycles after enable rises: enable high 10 cycles, then falls; dump follows. With MIPS_DBG_CYCLE_COUNT_EN, the last 4 bytes are 0A 00 00 00.
4. Push 8'h63 with halt already 1: zero enable cycles, dump follows. Push 8'h41: rd pulse, no enable, no wr.
5. Toggle tx_full high for 5 cycles during SEND: no wr while full, no byte skipped or duplicated, byte order preserved.
6. Assert reset for 1 cycle mid-SEND (after byte 20): wr=0 and enable=0 from the next cycle. A subsequent 8'h64 produces a fresh, complete 41-byte frame.

Source files
------------

// File: rtl/mips_debug_ctrl_pkg.sv
// ============================================================================
// Module   : mips_debug_ctrl_pkg
// Brief    : Shared definitions for the MIPS debug/run controller: debug bus
//            width, command codes and FSM state encoding.
// Revision : 1.0
// Note     : MIPS_DBG_CYCLE_COUNT_EN appends a 4-byte cycle count to each dump.
// ============================================================================
`default_nettype none

package mips_debug_ctrl_pkg;

    localparam int DEBUG_W_DEF = 322;
    localparam int CNT_BYTES   = 4;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_LATCH  = 3'd5,
        ST_SEND   = 3'd6
    } state_t;

    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_debug_ctrl_frame_tx.sv
// ============================================================================
// Module   : dbg_frame_tx
// Brief    : Latches a frame on i_start and streams it LSB-byte-first into the
//            UART tx FIFO, stalling while the FIFO reports full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dbg_frame_tx #(
    parameter int NBYTES = 41
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [8*NBYTES-1:0]   i_data,
    input  logic                  i_tx_full,
    output logic                  o_wr,
    output logic [7:0]            o_data,
    output logic                  o_done
);

    localparam int                 IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(NBYTES - 1);

    logic [8*NBYTES-1:0] r_snap;
    logic [IDX_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_wr;
    logic [7:0]          r_data;
    logic                r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_wr   <= 1'b0;
            r_data <= 8'h00;
            r_done <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            if (i_start) begin
                r_snap <= i_data;
                r_idx  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy && !i_tx_full) begin
                // Index only advances on an actual push, so a full FIFO never skips a byte.
                r_wr   <= 1'b1;
                r_data <= r_snap[{r_idx, 3'b000} +: 8];
                if (r_idx == C_LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_data = r_data;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/mips_debug_ctrl.sv
// ============================================================================
// Module   : mips_debug_ctrl
// Brief    : Command FSM between the UART FIFOs and the MIPS core: gates the
//            core enable for run/step and dumps the debug bus byte-serially.
// Revision : 1.0
// Note     : MIPS_DBG_CYCLE_COUNT_EN adds an enabled-cycle counter to the dump.
// ============================================================================
`default_nettype none

module mips_debug_ctrl
    import mips_debug_ctrl_pkg::*;
#(
    parameter int DEBUG_W = DEBUG_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_empty,
    output logic               rd,
    input  logic               tx_full,
    output logic               wr,
    output logic [7:0]         w_data,
    input  logic               halt,
    input  logic [DEBUG_W-1:0] debug_signal,
    output logic               enable
);

    localparam int NB = nbytes(DEBUG_W);
`ifdef MIPS_DBG_CYCLE_COUNT_EN
    localparam int FRAME_BYTES = NB + CNT_BYTES;
`else
    localparam int FRAME_BYTES = NB;
`endif

    state_t                   r_state;
    logic [7:0]               r_cmd;
    logic                     r_rd;
    logic                     r_enable;
    logic [8*NB-1:0]          w_pad;
    logic [8*FRAME_BYTES-1:0] w_frame;
    logic                     w_start;
    logic                     w_done;

    always_comb begin
        w_pad                = '0;
        w_pad[DEBUG_W-1:0]   = debug_signal;
    end

`ifdef MIPS_DBG_CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycles <= 32'd0;
        end else if (r_enable) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_frame = {r_cycles, w_pad};
`else
    assign w_frame = w_pad;
`endif

    // Enable is raised one cycle after entering RUN/STEP and always drops on
    // the edge that leaves them, so it is high only while in those states.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cmd    <= 8'h00;
            r_rd     <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_rd <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        r_cmd   <= rx_data;
                        r_rd    <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (r_cmd == CMD_RUN) begin
                        r_state <= halt ? ST_SETTLE : ST_RUN;
                    end else if (r_cmd == CMD_STEP) begin
                        r_state <= ST_STEP;
                    end else if (r_cmd == CMD_DUMP) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        r_enable <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end else begin
                        r_enable <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (!r_enable) begin
                        r_enable <= 1'b1;
                    end else begin
                        r_enable <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: r_state <= ST_LATCH;
                ST_LATCH:  r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_enable <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_start = (r_state == ST_LATCH);

    dbg_frame_tx #(
        .NBYTES (FRAME_BYTES)
    ) u_frame_tx (
        .clk       (clock),
        .rst       (reset),
        .i_start   (w_start),
        .i_data    (w_frame),
        .i_tx_full (tx_full),
        .o_wr      (wr),
        .o_data    (w_data),
        .o_done    (w_done)
    );

    assign rd     = r_rd;
    assign enable = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
// ============================================================================
// Module   : tb_mips_debug_ctrl
// Brief    : Directed self-checking bench for mips_debug_ctrl.
// Revision : 1.0
// Note     : MIPS_DBG_CYCLE_COUNT_EN enables the trailing cycle-count checks.
// ============================================================================
`default_nettype none

module tb_mips_debug_ctrl;

    localparam int DW = 322;
    localparam int NB = 41;
`ifdef MIPS_DBG_CYCLE_COUNT_EN
    localparam int FB = NB + 4;
`else
    localparam int FB = NB;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_empty = 1'b1;
    logic          rd;
    logic          tx_full = 1'b0;
    logic          wr;
    logic [7:0]    w_data;
    logic          halt = 1'b0;
    logic [DW-1:0] debug_signal = '0;
    logic          enable;

    mips_debug_ctrl #(.DEBUG_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rd           (rd),
        .tx_full      (tx_full),
        .wr           (wr),
        .w_data       (w_data),
        .halt         (halt),
        .debug_signal (debug_signal),
        .enable       (enable)
    );

    always #5 clock = ~clock;

    int         cyc = 0;
    int         rd_cnt, en_cnt, rd_cyc, en_rise, en_fall, first_wr, wr_full;
    int         overlap = 0;
    logic       en_prev = 1'b0;
    logic [7:0] bytes[$];
    logic [7:0] exp_b[NB];
    int         n_pass = 0;
    int         n_total = 0;

    // Observer: tx_full is captured at the edge the DUT sampled it.
    always @(posedge clock) begin : mon
        logic f;
        f = tx_full;
        #1;
        cyc++;
        if (rd) begin
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (enable) begin
            en_cnt++;
            if (!en_prev) en_rise = cyc;
        end
        if (!enable && en_prev) en_fall = cyc;
        en_prev = enable;
        if (wr) begin
            bytes.push_back(w_data);
            if (first_wr < 0) first_wr = cyc;
            if (f) wr_full++;
        end
        if (rd && wr) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic clr();
        rd_cnt = 0; en_cnt = 0; rd_cyc = -1; en_rise = -1; en_fall = -1;
        first_wr = -1; wr_full = 0;
        bytes.delete();
    endtask

    task automatic tick();
        @(negedge clock);
        if (rd) rx_empty = 1'b1;
    endtask

    task automatic set_dbg(input logic [7:0] base, input logic [1:0] top);
        for (int i = 0; i < NB - 1; i++) begin
            debug_signal[8*i +: 8] = base + 8'(i);
            exp_b[i]               = base + 8'(i);
        end
        debug_signal[DW-1 -: 2] = top;
        exp_b[NB-1]             = {6'b0, top};
    endtask

    task automatic push(input logic [7:0] c);
        @(negedge clock);
        clr();
        rx_data  = c;
        rx_empty = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t = 0;
        while (bytes.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic chk_frame(input string tag);
        int bad = 0;
        for (int i = 0; i < NB; i++) begin
            if (i >= bytes.size() || bytes[i] !== exp_b[i]) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] expv);
        logic [31:0] obs = 'x;
        if (bytes.size() >= FB) obs = {bytes[NB+3], bytes[NB+2], bytes[NB+1], bytes[NB]};
        chk(tag, 64'(obs), 64'(expv));
    endtask

    initial begin
        int t;
        int sz;
        clr();
        repeat (3) @(negedge clock);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_wdata", 64'(w_data), 64'd0);
        chk("rst_enable", 64'(enable), 64'd0);
        reset = 1'b0;

        // Dump only
        set_dbg(8'h10, 2'b10);
        push(8'h64);
        wait_bytes(FB, 120);
        repeat (5) tick();
        chk("dump_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("dump_en_cnt", 64'(en_cnt), 64'd0);
        chk("dump_nbytes", 64'(bytes.size()), 64'(FB));
        chk("dump_byte0", 64'(bytes.size() > 0 ? bytes[0] : 8'hxx), 64'h10);
        chk("dump_byte40", 64'(bytes.size() > 40 ? bytes[40] : 8'hxx), 64'h02);
        chk_frame("dump_frame");
`ifdef MIPS_DBG_CYCLE_COUNT_EN
        chk_cnt("dump_count", 32'd0);
`endif

        // Single step
        set_dbg(8'h55, 2'b01);
        push(8'h73);
        wait_bytes(FB, 120);
        repeat (5) tick();
        chk("step_en_cnt", 64'(en_cnt), 64'd1);
        chk("step_rd_to_en", 64'(en_rise - rd_cyc), 64'd2);
        chk("step_fall_to_wr", 64'(first_wr - en_fall), 64'd3);
        chk("step_nbytes", 64'(bytes.size()), 64'(FB));
        chk_frame("step_frame");
`ifdef MIPS_DBG_CYCLE_COUNT_EN
        chk_cnt("step_count", 32'd1);
`endif

        // Run until halt, 10 enabled cycles
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        set_dbg(8'hC0, 2'b11);
        push(8'h63);
        t = 0;
        while (!enable && t < 20) begin
            tick();
            t++;
        end
        repeat (9) tick();
        halt = 1'b1;
        wait_bytes(FB, 120);
        repeat (5) tick();
        chk("run_en_cnt", 64'(en_cnt), 64'd10);
        chk("run_fall_to_wr", 64'(first_wr - en_fall), 64'd3);
        chk("run_nbytes", 64'(bytes.size()), 64'(FB));
        chk_frame("run_frame");
`ifdef MIPS_DBG_CYCLE_COUNT_EN
        chk_cnt("run_count", 32'd10);
`endif

        // Run with halt already set, then an unknown command
        push(8'h63);
        wait_bytes(FB, 120);
        repeat (5) tick();
        chk("runh_en_cnt", 64'(en_cnt), 64'd0);
        chk("runh_nbytes", 64'(bytes.size()), 64'(FB));
        chk_frame("runh_frame");
`ifdef MIPS_DBG_CYCLE_COUNT_EN
        chk_cnt("runh_count", 32'd10);
`endif
        halt = 1'b0;
        push(8'h41);
        repeat (20) tick();
        chk("bad_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("bad_en_cnt", 64'(en_cnt), 64'd0);
        chk("bad_nbytes", 64'(bytes.size()), 64'd0);

        // Back-pressure during SEND
        set_dbg(8'h20, 2'b10);
        push(8'h64);
        wait_bytes(5, 120);
        tx_full = 1'b1;
        sz = bytes.size();
        repeat (5) tick();
        chk("full_hold", 64'(bytes.size()), 64'(sz));
        tx_full = 1'b0;
        wait_bytes(FB, 200);
        repeat (5) tick();
        chk("full_wr_while_full", 64'(wr_full), 64'd0);
        chk("full_nbytes", 64'(bytes.size()), 64'(FB));
        chk_frame("full_frame");

        // Reset mid-send, then a fresh dump
        set_dbg(8'h80, 2'b01);
        push(8'h64);
        wait_bytes(21, 120);
        reset = 1'b1;
        tick();
        chk("abort_wr", 64'(wr), 64'd0);
        chk("abort_enable", 64'(enable), 64'd0);
        reset = 1'b0;
        clr();
        repeat (10) tick();
        chk("abort_quiet", 64'(bytes.size()), 64'd0);
        push(8'h64);
        wait_bytes(FB, 120);
        repeat (5) tick();
        chk("redo_nbytes", 64'(bytes.size()), 64'(FB));
        chk_frame("redo_frame");
        chk("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
